// File: rtl/bnn_fc_xnor_classifier_if.sv
// Signal bundle between the pooled-feature source / weight ROM (master side)
// and the binary fully-connected classifier (slave side).
interface bnn_fc_xnor_classifier_if #(
  parameter int CHUNK       = 13,
  parameter int SCORE_WIDTH = 8,
  parameter int CLASS_WIDTH = 4,
  parameter int ADDR_WIDTH  = 8
);
  logic                   pixel_in;
  logic                   valid_in;
  logic [ADDR_WIDTH-1:0]  weight_addr;
  logic [CHUNK-1:0]       weight_data;
  logic [SCORE_WIDTH-1:0] score_out;
  logic [CLASS_WIDTH-1:0] score_class;
  logic                   score_valid;
  logic [CLASS_WIDTH-1:0] class_out;
  logic                   class_valid;
  logic                   busy;
  logic                   drop_err;

  modport slave (
    input  pixel_in, valid_in, weight_data,
    output weight_addr, score_out, score_class, score_valid,
           class_out, class_valid, busy, drop_err
  );

  modport master (
    output pixel_in, valid_in, weight_data,
    input  weight_addr, score_out, score_class, score_valid,
           class_out, class_valid, busy, drop_err
  );
endinterface

// File: rtl/bnn_fc_xnor_classifier.sv
// Binary FC output layer: collects one pooled frame, scores every class by
// XNOR-popcount against ROM weights CHUNK bits per cycle, then emits argmax.
module bnn_fc_xnor_classifier #(
  parameter int IN_BITS     = 169,
  parameter int NUM_CLASSES = 10,
  parameter int CHUNK       = 13,
  parameter int SCORE_WIDTH = 8,
  parameter int CLASS_WIDTH = 4,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  bnn_fc_xnor_classifier_if.slave     bus
);

  localparam int NUM_CHUNKS      = IN_BITS / CHUNK;
  localparam int CNT_WIDTH       = $clog2(IN_BITS);
  localparam int CHUNK_IDX_WIDTH = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int POP_WIDTH       = $clog2(CHUNK + 1);

  // DRAIN covers the two pipeline cycles after the last ROM address.
  typedef enum logic [1:0] {S_COLLECT, S_COMPUTE, S_DRAIN, S_FINISH} state_t;

  state_t                     state, state_next;
  logic [IN_BITS-1:0]         feature;
  logic [CNT_WIDTH-1:0]       bit_cnt;
  logic [CHUNK_IDX_WIDTH-1:0] issue_chunk, tag_chunk;
  logic [CLASS_WIDTH-1:0]     issue_class, tag_class, best_class;
  logic                       tag_valid;
  logic [SCORE_WIDTH-1:0]     acc, acc_next, best_score;
  logic [POP_WIDTH-1:0]       pop;
  logic [CHUNK-1:0]           feat_chunk, match;
  logic                       accept, last_bit, last_issue, tag_last_chunk, final_score;

  assign accept         = bus.valid_in && (state == S_COLLECT);
  assign last_bit       = (bit_cnt == CNT_WIDTH'(IN_BITS - 1));
  assign last_issue     = (issue_class == CLASS_WIDTH'(NUM_CLASSES - 1)) &&
                          (issue_chunk == CHUNK_IDX_WIDTH'(NUM_CHUNKS - 1));
  assign tag_last_chunk = (tag_chunk == CHUNK_IDX_WIDTH'(NUM_CHUNKS - 1));
  assign final_score    = bus.score_valid && (bus.score_class == CLASS_WIDTH'(NUM_CLASSES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_COLLECT;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_next = state;
    case (state)
      S_COLLECT: if (accept && last_bit) state_next = S_COMPUTE;
      S_COMPUTE: if (last_issue)         state_next = S_DRAIN;
      S_DRAIN:   if (final_score)        state_next = S_FINISH;
      S_FINISH:                          state_next = S_COLLECT;
    endcase
  end

  // Stage 2: weight_data belongs to the address issued one cycle earlier.
  always_comb begin
    feat_chunk = feature[int'(tag_chunk) * CHUNK +: CHUNK];
    match      = ~(feat_chunk ^ bus.weight_data);
    pop        = '0;
    for (int j = 0; j < CHUNK; j++) pop = pop + POP_WIDTH'(match[j]);
    acc_next   = ((tag_chunk == '0) ? {SCORE_WIDTH{1'b0}} : acc) + SCORE_WIDTH'(pop);
  end

  // NOTE: the feature store has no reset; every bit is rewritten before a frame is scored.
  always_ff @(posedge clk) begin
    if (accept) feature[bit_cnt] <= bus.pixel_in;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all regs update together.
    if (reset) begin
      bit_cnt         <= '0;
      issue_chunk     <= '0;
      issue_class     <= '0;
      tag_chunk       <= '0;
      tag_class       <= '0;
      tag_valid       <= 1'b0;
      acc             <= '0;
      best_score      <= '0;
      best_class      <= '0;
      bus.weight_addr <= '0;
      bus.score_out   <= '0;
      bus.score_class <= '0;
      bus.score_valid <= 1'b0;
      bus.class_out   <= '0;
      bus.class_valid <= 1'b0;
      bus.busy        <= 1'b0;
      bus.drop_err    <= 1'b0;
    end else begin
      bus.score_valid <= 1'b0;
      bus.class_valid <= 1'b0;
      tag_valid       <= 1'b0;
      bus.busy        <= (state_next != S_COLLECT);

      if (bus.valid_in && (state != S_COLLECT)) bus.drop_err <= 1'b1;

      if (accept) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        if (last_bit) begin
          bus.weight_addr <= '0;
          issue_chunk     <= '0;
          issue_class     <= '0;
        end
      end

      if (state == S_COMPUTE) begin
        tag_valid <= 1'b1;
        tag_chunk <= issue_chunk;
        tag_class <= issue_class;
        if (!last_issue) begin
          bus.weight_addr <= bus.weight_addr + 1'b1;
          if (issue_chunk == CHUNK_IDX_WIDTH'(NUM_CHUNKS - 1)) begin
            issue_chunk <= '0;
            issue_class <= issue_class + 1'b1;
          end else begin
            issue_chunk <= issue_chunk + 1'b1;
          end
        end
      end

      if (tag_valid) begin
        acc <= acc_next;
        if (tag_last_chunk) begin
          bus.score_valid <= 1'b1;
          bus.score_out   <= acc_next;
          bus.score_class <= tag_class;
          // Strictly greater keeps the lowest index on ties.
          if ((tag_class == '0) || (acc_next > best_score)) begin
            best_score <= acc_next;
            best_class <= tag_class;
          end
        end
      end

      if ((state == S_DRAIN) && final_score) begin
        bus.class_valid <= 1'b1;
        bus.class_out   <= best_class;
      end
    end
  end

endmodule

// File: tb/tb_bnn_fc_xnor_classifier.sv
// Directed bench for bnn_fc_xnor_classifier: hand-built frames and ROM images,
// with a small XNOR-popcount reference for the random cases.
module tb_bnn_fc_xnor_classifier;

  localparam int IN_BITS     = 169;
  localparam int NUM_CLASSES = 10;
  localparam int CHUNK       = 13;
  localparam int NUM_CHUNKS  = 13;
  localparam int ROM_DEPTH   = NUM_CLASSES * NUM_CHUNKS;
  localparam int FRAME_LAT   = 132;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [CHUNK-1:0] rom [ROM_DEPTH];
  int               got_score [NUM_CLASSES];
  int               got_class;

  bnn_fc_xnor_classifier_if bus ();

  bnn_fc_xnor_classifier dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous weight ROM: data follows the address by one cycle.
  always @(posedge clk)
    bus.weight_data <= (int'(bus.weight_addr) < ROM_DEPTH) ? rom[bus.weight_addr] : '0;

  function automatic int model_score(input logic [IN_BITS-1:0] f, input int c);
    int s;
    logic [CHUNK-1:0] w;
    s = 0;
    for (int b = 0; b < IN_BITS; b++) begin
      w = rom[c * NUM_CHUNKS + b / CHUNK];
      if (f[b] == w[b % CHUNK]) s++;
    end
    return s;
  endfunction

  function automatic logic [IN_BITS-1:0] rand_frame();
    logic [IN_BITS-1:0] r;
    for (int b = 0; b < IN_BITS; b++) r[b] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic check_idle(input string tag);
    logic [27:0] v;
    v = {bus.weight_addr, bus.score_out, bus.score_class, bus.score_valid,
         bus.class_out, bus.class_valid, bus.busy, bus.drop_err};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: outputs after reset = %h, required 0", tag, v);
    end
  endtask

  task automatic send_bits(input logic [IN_BITS-1:0] f, input int n, input bit gaps);
    int i;
    i = 0;
    while (i < n) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.valid_in = 1'b0;
        bus.pixel_in = ~f[i];
      end else begin
        bus.valid_in = 1'b1;
        bus.pixel_in = f[i];
        i++;
      end
    end
  endtask

  // Sends a frame, then follows the score/class pulses against the reference.
  task automatic run_frame(input string tag, input logic [IN_BITS-1:0] f,
                           input bit gaps, input bit hold);
    int exp_score [NUM_CLASSES];
    int exp_class;
    int n;
    bit seen;
    for (int c = 0; c < NUM_CLASSES; c++) exp_score[c] = model_score(f, c);
    exp_class = 0;
    for (int c = 1; c < NUM_CLASSES; c++)
      if (exp_score[c] > exp_score[exp_class]) exp_class = c;

    send_bits(f, IN_BITS, gaps);
    @(negedge clk);
    bus.valid_in = hold;
    bus.pixel_in = 1'b1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_last_bit: got %b, required 1", tag, bus.busy);
    end

    n = 0;
    seen = 1'b0;
    got_class = -1;
    for (int k = 1; k <= FRAME_LAT + 40 && !seen; k++) begin
      @(negedge clk);
      if (hold) bus.pixel_in = 1'($urandom_range(0, 1));
      if (bus.score_valid === 1'b1) begin
        if (n < NUM_CLASSES) begin
          got_score[n] = int'(bus.score_out);
          checks++;
          if (bus.score_class !== 4'(n)) begin
            errors++;
            $display("FAIL %s score_class[%0d]: got %0d, required %0d", tag, n, bus.score_class, n);
          end
          checks++;
          if (bus.score_out !== 8'(exp_score[n])) begin
            errors++;
            $display("FAIL %s score[%0d]: got %0d, required %0d", tag, n, bus.score_out, exp_score[n]);
          end
          checks++;
          if (k != 13 * n + 14) begin
            errors++;
            $display("FAIL %s score_time[%0d]: got cycle %0d, required %0d", tag, n, k, 13 * n + 14);
          end
        end else begin
          checks++;
          errors++;
          $display("FAIL %s extra_score: got pulse %0d, required at most %0d", tag, n + 1, NUM_CLASSES);
        end
        n++;
      end
      if (bus.class_valid === 1'b1) begin
        seen = 1'b1;
        got_class = int'(bus.class_out);
        checks++;
        if (n != NUM_CLASSES) begin
          errors++;
          $display("FAIL %s score_count: got %0d, required %0d", tag, n, NUM_CLASSES);
        end
        checks++;
        if (bus.class_out !== 4'(exp_class)) begin
          errors++;
          $display("FAIL %s class_out: got %0d, required %0d", tag, bus.class_out, exp_class);
        end
        checks++;
        if (k != FRAME_LAT) begin
          errors++;
          $display("FAIL %s class_latency: got %0d, required %0d", tag, k, FRAME_LAT);
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s class_valid_timeout: got none, required pulse at cycle %0d", tag, FRAME_LAT);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.valid_in = 1'b0;
    bus.pixel_in = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_initial");
    reset = 1'b0;
  endtask

  task automatic test_all_ones();
    for (int a = 0; a < ROM_DEPTH; a++) rom[a] = (a / NUM_CHUNKS == 3) ? '1 : '0;
    run_frame("all_ones", '1, 1'b0, 1'b0);
    checks++;
    if (got_score[3] != 169) begin errors++; $display("FAIL ones_score3: got %0d, required 169", got_score[3]); end
    checks++;
    if (got_score[0] != 0) begin errors++; $display("FAIL ones_score0: got %0d, required 0", got_score[0]); end
    checks++;
    if (got_score[9] != 0) begin errors++; $display("FAIL ones_score9: got %0d, required 0", got_score[9]); end
    checks++;
    if (got_class != 3) begin errors++; $display("FAIL ones_class: got %0d, required 3", got_class); end
  endtask

  task automatic test_all_zeros();
    for (int a = 0; a < ROM_DEPTH; a++) rom[a] = '0;
    run_frame("all_zeros", '0, 1'b0, 1'b0);
    for (int c = 0; c < NUM_CLASSES; c++) begin
      checks++;
      if (got_score[c] != 169) begin
        errors++;
        $display("FAIL zeros_score[%0d]: got %0d, required 169", c, got_score[c]);
      end
    end
    checks++;
    if (got_class != 0) begin errors++; $display("FAIL zeros_tie_class: got %0d, required 0", got_class); end
  endtask

  task automatic test_random_gaps();
    for (int a = 0; a < ROM_DEPTH; a++) rom[a] = 13'($urandom);
    run_frame("random_gaps", rand_frame(), 1'b1, 1'b0);
    checks++;
    if (bus.drop_err !== 1'b0) begin errors++; $display("FAIL gaps_drop_err: got %b, required 0", bus.drop_err); end
  endtask

  task automatic test_drop();
    run_frame("drop_hold", rand_frame(), 1'b0, 1'b1);
    checks++;
    if (bus.drop_err !== 1'b1) begin errors++; $display("FAIL drop_err_set: got %b, required 1", bus.drop_err); end
    run_frame("after_drop", rand_frame(), 1'b0, 1'b0);
    checks++;
    if (bus.drop_err !== 1'b1) begin errors++; $display("FAIL drop_err_sticky: got %b, required 1", bus.drop_err); end
  endtask

  task automatic test_reset_mid();
    logic [IN_BITS-1:0] f;
    bit found;
    f = rand_frame();
    send_bits(f, 80, 1'b0);
    @(negedge clk);
    bus.valid_in = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    check_idle("reset_mid_collect");
    reset = 1'b0;

    send_bits(f, IN_BITS, 1'b0);
    @(negedge clk);
    bus.valid_in = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (bus.weight_addr === 8'd57) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL reset_mid_addr_timeout: got addr %0d, required 57", bus.weight_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    check_idle("reset_mid_compute");
    reset = 1'b0;

    run_frame("after_reset", rand_frame(), 1'b0, 1'b0);
    checks++;
    if (bus.drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop_err: got %b, required 0", bus.drop_err); end
  endtask

  task automatic test_back_to_back();
    int first_class;
    for (int a = 0; a < ROM_DEPTH; a++)
      rom[a] = (a / NUM_CHUNKS == 2) ? 13'h0000 : (a / NUM_CHUNKS == 7) ? 13'h1FFF : 13'h0AAA;
    run_frame("b2b_first", '0, 1'b0, 1'b0);
    first_class = got_class;
    run_frame("b2b_second", '1, 1'b0, 1'b0);
    checks++;
    if (first_class != 2) begin errors++; $display("FAIL b2b_class_a: got %0d, required 2", first_class); end
    checks++;
    if (got_class != 7) begin errors++; $display("FAIL b2b_class_b: got %0d, required 7", got_class); end
    checks++;
    if (got_score[0] != 78) begin errors++; $display("FAIL b2b_score0_b: got %0d, required 78", got_score[0]); end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_random_gaps();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bnn_fc_xnor_classifier.md
Name: bnn_fc_xnor_classifier

Overview:
- Binary fully-connected output layer; sits directly downstream of the 2x2 binary maxpool stage.
- Collects one pooled feature map (raster order, 1 bit per pixel) into an internal feature register.
- Computes XNOR-popcount scores against per-class binary weights read from an external synchronous ROM, CHUNK bits per cycle.
- Emits every class score, then the argmax class index. Fixed feature-map size per frame; no backpressure upstream.

Parameters:
- IN_BITS, 169, feature bits per frame (13x13 pooled map).
- NUM_CLASSES, 10, number of output neurons.
- CHUNK, 13, feature/weight bits processed per compute cycle; IN_BITS must be a multiple of CHUNK.
- NUM_CHUNKS, IN_BITS/CHUNK (13), derived; do not override.
- SCORE_WIDTH, 8, score width; must hold IN_BITS (>= clog2(IN_BITS+1)).
- CLASS_WIDTH, 4, class index width (>= clog2(NUM_CLASSES)).
- ADDR_WIDTH, 8, weight ROM address width (>= clog2(NUM_CLASSES*NUM_CHUNKS)).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- pixel_in, input, 1, pooled feature bit.
- valid_in, input, 1, pixel_in qualifier.
- weight_addr, output, ADDR_WIDTH, ROM address = class*NUM_CHUNKS + chunk.
- weight_data, input, CHUNK, ROM data; valid 1 cycle after weight_addr. Bit j = weight for feature bit chunk*CHUNK+j.
- score_out, output, SCORE_WIDTH, class score.
- score_class, output, CLASS_WIDTH, class index of score_out.
- score_valid, output, 1, 1-cycle pulse per class score.
- class_out, output, CLASS_WIDTH, argmax class.
- class_valid, output, 1, 1-cycle pulse per frame.
- busy, output, 1, high in COMPUTE/FINISH.
- drop_err, output, 1, sticky: valid_in seen while busy.

Behaviour:
- Reset (synchronous, overrides everything, legal mid-frame or mid-compute):
  - State = COLLECT; bit counter, accumulator and best-score register cleared.
  - All outputs 0: weight_addr, score_out, score_class, score_valid, class_out, class_valid, busy, drop_err.
  - A partial frame is discarded.
- COLLECT:
  - Each cycle with valid_in=1, feature[cnt] <= pixel_in, then cnt++. The first received bit is feature[0].
  - When the bit at cnt = IN_BITS-1 is captured: cnt <= 0, state -> COMPUTE, busy=1 from the next cycle.
  - Gaps in valid_in are allowed.
- COMPUTE:
  - weight_addr steps 0,1,...,NUM_CLASSES*NUM_CHUNKS-1, one address per cycle, no stalls. The first address is presented on the first COMPUTE cycle.
  - Cycle after each address: acc <= (chunk==0 ? 0 : acc) + popcount(~(feature_chunk ^ weight_data)). Addition is unsigned and never overflows SCORE_WIDTH.
  - score_valid pulses exactly 2 cycles after the address of a class's last chunk is presented, with score_out = acc and score_class = c.
  - Scores are emitted in class order 0..NUM_CLASSES-1, each exactly NUM_CHUNKS cycles apart.
- Argmax:
  - Updated on each score_valid; replace the running best only if score > best (strictly greater).
  - Ties keep the lowest index. Class 0 always initialises the best.
- FINISH:
  - class_valid pulses 1 cycle after the last score_valid, with class_out = argmax.
  - class_out holds until the next class_valid or reset.
  - Same cycle: busy <= 0, state -> COLLECT.
  - Frame latency: last input bit to class_valid = NUM_CLASSES*NUM_CHUNKS + 2 cycles (132 at defaults).
- Input while busy: the bit is dropped (not stored, counter unchanged), drop_err <= 1 and stays set until reset.
  - valid_in on the same cycle class_valid asserts is also dropped.
  - The next frame starts with the first valid_in after busy falls.
- weight_addr holds its last value outside COMPUTE; weight_data is ignored outside COMPUTE.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- All-ones frame (169 ones); ROM class 3 all ones, other classes all zeros -> score 169 for class 3, 0 for the rest; class_out=3; class_valid 132 cycles after the last bit.
- All-zeros frame; ROM all zeros -> every score 169; tie, so class_out=0. Ten score_valid pulses, 13 cycles apart, score_class 0..9.
- Random frame and random ROM, with gaps in valid_in -> each score matches a reference XNOR-popcount model; class_out = lowest index with the max score.
- valid_in held high through COMPUTE -> drop_err=1, the results equal the no-extra-input case, and the following frame is collected from bit 0 after busy=0.
- Reset asserted at mid-collect (bit 80) and at mid-compute (weight_addr=57) -> all outputs 0 the next cycle; a following clean frame gives the correct result and drop_err=0.
- Two back-to-back frames, the second starting the cycle after class_valid -> two correct, independent class_out values.
